ai_matmul_sequencer: RTL and testbench

Control engine behind the accelerator's "go" register (config offset 5). It latches op/dimension config, validates it, and walks the A/B operand memories with nested i/j/k counters. It drives a multiply-accumulate datapath and writes each result into the C memory, which the Wishbone slave later reads back. It sits between the Wishbone register file and the three matrix RAMs, and is the only writer of C.

---
 rtl/ai_accel_pkg.sv | 30 +++
 rtl/ai_mac_unit.sv | 75 +++++++
 rtl/ai_matmul_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ai_matmul_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ai_accel_pkg.sv
// Shared constants and types for the matrix accelerator: opcodes, sequencer
// states, Wishbone region selectors and config register offsets.
package ai_accel_pkg;

  localparam logic [7:0] OP_MATMUL = 8'd1;
  localparam logic [7:0] OP_ADD    = 8'd2;

  localparam logic [1:0] REGION_CFG = 2'b00;
  localparam logic [1:0] REGION_A   = 2'b01;
  localparam logic [1:0] REGION_B   = 2'b10;
  localparam logic [1:0] REGION_C   = 2'b11;

  localparam logic [2:0] CFG_OP = 3'd0;
  localparam logic [2:0] CFG_WA = 3'd1;
  localparam logic [2:0] CFG_HA = 3'd2;
  localparam logic [2:0] CFG_WB = 3'd3;
  localparam logic [2:0] CFG_HB = 3'd4;
  localparam logic [2:0] CFG_GO = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } seq_state_t;

endpackage

// File: rtl/ai_mac_unit.sv
// Registered multiply/add/accumulate for the sequencer. With SEQ_SATURATE_EN
// defined both the product and the running sum clamp to all-ones and set ovf.
module ai_mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic              op_add,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
`ifdef SEQ_SATURATE_EN
  ,
  input  logic              clr,
  output logic              ovf
`endif
);

  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;

`ifdef SEQ_SATURATE_EN
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum_full;
  logic                prod_sat;
  logic                sat;

  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    prod_sat = !op_add && (|prod[2*DATA_W-1:ACC_W]);
    if (op_add) begin
      base   = ACC_W'(a);
      addend = ACC_W'(b);
    end else begin
      base   = first ? '0 : acc;
      addend = prod_sat ? '1 : prod[ACC_W-1:0];
    end
    sum_full = {1'b0, base} + {1'b0, addend};
    sat      = prod_sat || sum_full[ACC_W];
    sum      = sat ? '1 : sum_full[ACC_W-1:0];
  end
`else
  always_comb begin
    if (op_add) begin
      base   = ACC_W'(a);
      addend = ACC_W'(b);
    end else begin
      base   = first ? '0 : acc;
      addend = ACC_W'(a * b);
    end
    sum = base + addend;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
`ifdef SEQ_SATURATE_EN
      ovf <= 1'b0;
`endif
    end else begin
      if (en) acc <= sum;
`ifdef SEQ_SATURATE_EN
      if (clr) ovf <= 1'b0;
      else if (en && sat) ovf <= 1'b1;
`endif
    end
  end

endmodule

// File: rtl/ai_matmul_sequencer.sv
// Sequencer behind the accelerator "go" register: validates config, walks A/B
// with i/j/k counters and writes C. SEQ_SATURATE_EN adds saturation and ovf_o.
//
// state | meaning
// IDLE  | waiting for go
// CHECK | validate latched config
// ISSUE | one A/B read per cycle, k advancing
// DRAIN | last operand pair lands in the MAC
// WRITE | store acc into C{i,j}, advance j/i
// DONE  | done pulse, success
// ERR   | done pulse with err_o
module ai_matmul_sequencer
  import ai_accel_pkg::*;
#(
  parameter int IDX_W  = 15,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic               wishbone_clk_i,
  input  logic               wishbone_rst_i,
  input  logic [7:0]         cfg_op_i,
  input  logic [IDX_W-1:0]   cfg_wa_i,
  input  logic [IDX_W-1:0]   cfg_ha_i,
  input  logic [IDX_W-1:0]   cfg_wb_i,
  input  logic [IDX_W-1:0]   cfg_hb_i,
  input  logic               go_i,
  output logic               a_rd_o,
  output logic [2*IDX_W-1:0] a_addr_o,
  input  logic [DATA_W-1:0]  a_data_i,
  output logic               b_rd_o,
  output logic [2*IDX_W-1:0] b_addr_o,
  input  logic [DATA_W-1:0]  b_data_i,
  output logic               c_we_o,
  output logic [2*IDX_W-1:0] c_addr_o,
  output logic [ACC_W-1:0]   c_data_o,
  output logic               busy_o,
  output logic               done_o,
`ifdef SEQ_SATURATE_EN
  output logic               ovf_o,
`endif
  output logic               err_o
);

  seq_state_t       state;
  logic [7:0]       op_q;
  logic [IDX_W-1:0] wa_q, ha_q, wb_q, hb_q;
  logic [IDX_W-1:0] i_q, j_q, k_q, k_nxt, i_nxt, j_nxt;
  logic             issue_first, rd_d, first_d;
  logic             go_acc, is_add, cfg_bad, last_k, last_elem, j_wrap;

  assign go_acc    = go_i && (state == ST_IDLE);
  assign is_add    = (op_q == OP_ADD);
  assign cfg_bad   = !((op_q == OP_MATMUL) || is_add)
                  || (wa_q == '0) || (ha_q == '0) || (wb_q == '0) || (hb_q == '0)
                  || (!is_add && (wa_q != hb_q))
                  || (is_add && ((wa_q != wb_q) || (ha_q != hb_q)));
  assign last_k    = is_add || (k_q == wa_q - IDX_W'(1));
  assign j_wrap    = (j_q == wb_q - IDX_W'(1));
  assign last_elem = j_wrap && (i_q == ha_q - IDX_W'(1));
  assign k_nxt     = k_q + IDX_W'(1);
  assign j_nxt     = j_wrap ? '0 : j_q + IDX_W'(1);
  assign i_nxt     = j_wrap ? i_q + IDX_W'(1) : i_q;

  always_ff @(posedge wishbone_clk_i or posedge wishbone_rst_i) begin
    if (wishbone_rst_i) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      {wa_q, ha_q, wb_q, hb_q} <= '0;
      {i_q, j_q, k_q}          <= '0;
      issue_first <= 1'b0;
      rd_d        <= 1'b0;
      first_d     <= 1'b0;
      a_rd_o      <= 1'b0;
      b_rd_o      <= 1'b0;
      a_addr_o    <= '0;
      b_addr_o    <= '0;
      c_we_o      <= 1'b0;
      c_addr_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      // read data returns one cycle after the strobe, so the MAC enable trails it
      rd_d    <= a_rd_o;
      first_d <= issue_first;
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (go_acc) begin
            op_q   <= cfg_op_i;
            wa_q   <= cfg_wa_i;
            ha_q   <= cfg_ha_i;
            wb_q   <= cfg_wb_i;
            hb_q   <= cfg_hb_i;
            busy_o <= 1'b1;
            err_o  <= 1'b0;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cfg_bad) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= ST_ERR;
          end else begin
            {i_q, j_q, k_q} <= '0;
            issue_first <= 1'b1;
            a_rd_o      <= 1'b1;
            b_rd_o      <= 1'b1;
            a_addr_o    <= '0;
            b_addr_o    <= '0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          issue_first <= 1'b0;
          if (last_k) begin
            a_rd_o <= 1'b0;
            b_rd_o <= 1'b0;
            state  <= ST_DRAIN;
          end else begin
            k_q      <= k_nxt;
            a_addr_o <= {i_q, k_nxt};
            b_addr_o <= {k_nxt, j_q};
          end
        end
        ST_DRAIN: begin
          c_we_o   <= 1'b1;
          c_addr_o <= {i_q, j_q};
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          c_we_o <= 1'b0;
          if (last_elem) begin
            done_o <= 1'b1;
            state  <= ST_DONE;
          end else begin
            i_q         <= i_nxt;
            j_q         <= j_nxt;
            k_q         <= '0;
            issue_first <= 1'b1;
            a_rd_o      <= 1'b1;
            b_rd_o      <= 1'b1;
            a_addr_o    <= is_add ? {i_nxt, j_nxt} : {i_nxt, {IDX_W{1'b0}}};
            b_addr_o    <= is_add ? {i_nxt, j_nxt} : {{IDX_W{1'b0}}, j_nxt};
            state       <= ST_ISSUE;
          end
        end
        ST_DONE, ST_ERR: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ai_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk    (wishbone_clk_i),
    .rst    (wishbone_rst_i),
    .en     (rd_d),
    .first  (first_d),
    .op_add (is_add),
    .a      (a_data_i),
    .b      (b_data_i),
    .acc    (c_data_o)
`ifdef SEQ_SATURATE_EN
    ,
    .clr    (go_acc),
    .ovf    (ovf_o)
`endif
  );

endmodule

// File: tb/tb_ai_matmul_sequencer.sv
// Directed, table-driven bench for ai_matmul_sequencer with hand-computed results.
module tb_ai_matmul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cfg_op = 8'd0;
  logic [14:0] cfg_wa = '0, cfg_ha = '0, cfg_wb = '0, cfg_hb = '0;
  logic        go = 1'b0;
  logic        a_rd, b_rd, c_we, busy, done, err;
  logic [29:0] a_addr, b_addr, c_addr;
  logic [31:0] a_data = '0, b_data = '0, c_data;
  logic        ovf;

  always #5 clk = ~clk;

  ai_matmul_sequencer dut (
    .wishbone_clk_i (clk),
    .wishbone_rst_i (rst),
    .cfg_op_i       (cfg_op),
    .cfg_wa_i       (cfg_wa),
    .cfg_ha_i       (cfg_ha),
    .cfg_wb_i       (cfg_wb),
    .cfg_hb_i       (cfg_hb),
    .go_i           (go),
    .a_rd_o         (a_rd),
    .a_addr_o       (a_addr),
    .a_data_i       (a_data),
    .b_rd_o         (b_rd),
    .b_addr_o       (b_addr),
    .b_data_i       (b_data),
    .c_we_o         (c_we),
    .c_addr_o       (c_addr),
    .c_data_o       (c_data),
    .busy_o         (busy),
    .done_o         (done),
`ifdef SEQ_SATURATE_EN
    .ovf_o          (ovf),
`endif
    .err_o          (err)
  );

`ifndef SEQ_SATURATE_EN
  assign ovf = 1'b0;
`endif

  // Operand patterns: 0 -> A=row, B=col; 2 -> all ones; 3 -> A=row+2, B=col+3
  int cur_pat = 0;
  function automatic logic [31:0] pat_val(input int p, input bit is_b, input logic [29:0] ad);
    int r, c;
    r = int'(ad[29:15]);
    c = int'(ad[14:0]);
    case (p)
      0:       return 32'(is_b ? c : r);
      2:       return 32'hFFFF_FFFF;
      default: return 32'(is_b ? c + 3 : r + 2);
    endcase
  endfunction

  logic [31:0] c_mem [0:15][0:15];
  logic        c_clr = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0;

  always @(posedge clk) begin
    a_data <= a_rd ? pat_val(cur_pat, 1'b0, a_addr) : 32'h0;
    b_data <= b_rd ? pat_val(cur_pat, 1'b1, b_addr) : 32'h0;
    if (a_rd) rd_cnt <= rd_cnt + 1;
    if (c_we) wr_cnt <= wr_cnt + 1;
    if ((a_rd || b_rd) && c_we) overlap_cnt <= overlap_cnt + 1;
    if (c_clr) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) c_mem[r][c] <= 32'hDEAD_BEEF;
    end else if (c_we) begin
      c_mem[c_addr[18:15]][c_addr[3:0]] <= c_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_c();
    @(negedge clk);
    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0;
  endtask

  // Starts a run and returns the number of rising edges, counting the accept
  // edge as 1, until done_o is observed.
  task automatic run(input logic [7:0] op, input int wa, input int ha, input int wb, input int hb,
                     input bit disturb, output int lat, output bit busy_at_done);
    @(negedge clk);
    cfg_op = op;
    cfg_wa = 15'(wa);
    cfg_ha = 15'(ha);
    cfg_wb = 15'(wb);
    cfg_hb = 15'(hb);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    lat = 1;
    while (!done && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 100) begin
        go = 1'b1;
        cfg_wa = 15'd3;
      end
      if (disturb && lat == 101) go = 1'b0;
    end
    busy_at_done = busy;
  endtask

  typedef struct {
    logic [7:0]  op;
    int          wa, ha, wb, hb;
    int          pat;
    int          lat;
    bit          err;
    int          nrd, nwr;
    int          r0, c0;
    logic [31:0] e0;
    int          r1, c1;
    logic [31:0] e1;
    bit          ovf;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat, rd0, wr0;
    bit bz;
    bit found;
    logic [31:0] ovf_c;
    bit ovf_e;
`ifdef SEQ_SATURATE_EN
    ovf_c = 32'hFFFF_FFFF;
    ovf_e = 1'b1;
`else
    ovf_c = 32'h0000_0002;
    ovf_e = 1'b0;
`endif
    //            op    wa  ha  wb  hb pat  lat  err  nrd  nwr  r0 c0 e0     r1 c1 e1     ovf
    tbl[0] = '{8'd1, 15, 15, 15, 15, 0, 3827, 1'b0, 3375, 225, 2, 3, 32'd90, 14, 14, 32'd2940, 1'b0};
    tbl[1] = '{8'd2,  4,  3,  4,  3, 0,   38, 1'b0,   12,  12, 2, 3, 32'd5,   1,  0, 32'd1,    1'b0};
    tbl[2] = '{8'd7,  1,  1,  1,  1, 0,    2, 1'b1,    0,   0, 0, 0, 32'd0,   0,  0, 32'd0,    1'b0};
    tbl[3] = '{8'd1,  4,  2,  2,  5, 0,    2, 1'b1,    0,   0, 0, 0, 32'd0,   0,  0, 32'd0,    1'b0};
    tbl[4] = '{8'd1,  0,  1,  1,  0, 0,    2, 1'b1,    0,   0, 0, 0, 32'd0,   0,  0, 32'd0,    1'b0};
    tbl[5] = '{8'd1,  2,  1,  1,  2, 2,    6, 1'b0,    2,   1, 0, 0, ovf_c,   0,  0, ovf_c,    ovf_e};
    tbl[6] = '{8'd1,  1,  1,  1,  1, 3,    5, 1'b0,    1,   1, 0, 0, 32'd6,   0,  0, 32'd6,    1'b0};
    tbl[7] = '{8'd1,  3,  2,  2,  3, 3,   22, 1'b0,   12,   4, 0, 1, 32'd24,  1,  0, 32'd27,   1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_strobes", {29'd0, a_rd, b_rd, c_we}, 32'd0);
    chk("reset_c_data", c_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      cur_pat = tbl[t].pat;
      clear_c();
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      run(tbl[t].op, tbl[t].wa, tbl[t].ha, tbl[t].wb, tbl[t].hb, 1'b0, lat, bz);
      chk($sformatf("v%0d_latency", t), 32'(lat), 32'(tbl[t].lat));
      chk($sformatf("v%0d_err", t), {31'd0, err}, {31'd0, tbl[t].err});
      chk($sformatf("v%0d_busy_at_done", t), {31'd0, bz}, 32'd1);
      chk($sformatf("v%0d_ovf", t), {31'd0, ovf}, {31'd0, tbl[t].ovf});
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", t), {30'd0, done, busy}, 32'd0);
      chk($sformatf("v%0d_reads", t), 32'(rd_cnt - rd0), 32'(tbl[t].nrd));
      chk($sformatf("v%0d_writes", t), 32'(wr_cnt - wr0), 32'(tbl[t].nwr));
      if (!tbl[t].err) begin
        chk($sformatf("v%0d_c0", t), c_mem[tbl[t].r0][tbl[t].c0], tbl[t].e0);
        chk($sformatf("v%0d_c1", t), c_mem[tbl[t].r1][tbl[t].c1], tbl[t].e1);
      end
    end

    // go and cfg changes mid-run must be ignored
    cur_pat = 0;
    clear_c();
    run(8'd1, 15, 15, 15, 15, 1'b1, lat, bz);
    chk("disturb_latency", 32'(lat), 32'd3827);
    chk("disturb_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("disturb_c_2_3", c_mem[2][3], 32'd90);
    chk("disturb_c_14_1", c_mem[14][1], 32'd210);
    chk("disturb_c_14_14", c_mem[14][14], 32'd2940);

    // async reset in the middle of a WRITE cycle
    clear_c();
    @(negedge clk);
    cfg_op = 8'd1;
    cfg_wa = 15'd15; cfg_ha = 15'd15; cfg_wb = 15'd15; cfg_hb = 15'd15;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      if (c_we) found = 1'b1;
    end
    chk("rst_reach_write", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_strobes", {29'd0, a_rd, b_rd, c_we}, 32'd0);
    chk("rst_async_status", {29'd0, busy, done, err}, 32'd0);
    chk("rst_async_c_data", c_data, 32'd0);
    chk("rst_async_addr", {2'd0, c_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cur_pat = 3;
    run(8'd1, 1, 1, 1, 1, 1'b0, lat, bz);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_c", c_mem[0][0], 32'd6);

    chk("strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
